// File: rtl/led_shift_sequencer.sv
// Command-queued LED rotation controller: commands {pattern, dir, steps} are
// buffered in a small FIFO and executed back-to-back, one rotation per tick period.
`timescale 1ns/1ps
module led_shift_sequencer #(
    parameter int TICK_CYCLES = 25_000_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [7:0]                    cmd_pattern,
    input  logic                          cmd_dir,
    input  logic [7:0]                    cmd_steps,
    input  logic                          pause,
    output logic [7:0]                    leds,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam int          TICK_W    = $clog2(TICK_CYCLES);
    localparam logic [31:0] TICK_LAST = 32'(TICK_CYCLES - 1);

    typedef struct packed {
        logic [7:0] pattern;
        logic       dir;
        logic [7:0] steps;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    // ---------------------------------------------------------------- FIFO
    cmd_t              mem [FIFO_DEPTH];
    cmd_t              head_reg;
    cmd_t              entry_in;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    state_t            state_reg;
    state_t            state_next;

    assign entry_in  = '{pattern: cmd_pattern, dir: cmd_dir, steps: cmd_steps};
    assign full      = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_reg == '0);
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_reg == S_IDLE) && !empty;

    // Storage has no reset so it maps onto RAM; the head entry is read on the
    // pop edge and consumed in LOAD one cycle later.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= entry_in;
        end
        if (pop) begin
            head_reg <= mem[rd_ptr_reg];
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // ---------------------------------------------------------------- rotation
    logic [7:0] leds_reg;
    logic [7:0] leds_next;
    logic [7:0] rot_left;
    logic [7:0] rot_right;

    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
        assign rot_left[gi]  = leds_reg[(gi + 7) % 8];
        assign rot_right[gi] = leds_reg[(gi + 1) % 8];
    end

    // ---------------------------------------------------------------- FSM
    logic [TICK_W-1:0] tick_reg;
    logic [TICK_W-1:0] tick_next;
    logic [7:0]        step_reg;
    logic [7:0]        step_next;
    logic              dir_reg;
    logic              dir_next;
    logic              busy_reg;
    logic              done_reg;

    always_comb begin
        state_next = state_reg;
        leds_next  = leds_reg;
        tick_next  = tick_reg;
        step_next  = step_reg;
        dir_next   = dir_reg;
        case (state_reg)
            S_IDLE: begin
                if (!empty) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                leds_next  = head_reg.pattern;
                step_next  = head_reg.steps;
                dir_next   = head_reg.dir;
                tick_next  = '0;
                state_next = (head_reg.steps == 8'd0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (!pause) begin
                    // Full 32-bit compare so the terminal count is never truncated.
                    if (32'(tick_reg) == TICK_LAST) begin
                        tick_next = '0;
                        leds_next = dir_reg ? rot_right : rot_left;
                        step_next = step_reg - 8'd1;
                        if (step_reg == 8'd1) begin
                            state_next = S_DONE;
                        end
                    end else begin
                        tick_next = tick_reg + TICK_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            leds_reg  <= 8'h00;
            tick_reg  <= '0;
            step_reg  <= 8'd0;
            dir_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            leds_reg  <= leds_next;
            tick_reg  <= tick_next;
            step_reg  <= step_next;
            dir_reg   <= dir_next;
            busy_reg  <= (state_next != S_IDLE);
            done_reg  <= (state_next == S_DONE);
        end
    end

    assign leds       = leds_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign fifo_count = count_reg;

endmodule

// File: tb/tb_led_shift_sequencer.sv
// Directed bench for led_shift_sequencer with a leds/done scoreboard fed from
// an independent rotation model at command acceptance.
`timescale 1ns/1ps
module tb_led_shift_sequencer;

    localparam int TC = 4;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_pattern = 8'h00;
    logic       cmd_dir = 1'b0;
    logic [7:0] cmd_steps = 8'h00;
    logic       pause = 1'b0;
    logic [7:0] leds;
    logic       busy;
    logic       done;
    logic [2:0] fifo_count;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         done_cnt = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_leds[$];
    logic [7:0] exp_done[$];
    logic [7:0] model_last = 8'h00;
    logic [7:0] prev_leds = 8'h00;

    led_shift_sequencer #(.TICK_CYCLES(TC), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_pattern(cmd_pattern),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .pause      (pause),
        .leds       (leds),
        .busy       (busy),
        .done       (done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected visible leds changes and final value at each done pulse.
    task automatic model_cmd(input logic [7:0] p, input logic d, input logic [7:0] s);
        logic [7:0] v;
        logic [7:0] nv;
        v = p;
        if (v != model_last) exp_leds.push_back(v);
        for (int k = 0; k < int'(s); k++) begin
            nv = d ? {v[0], v[7:1]} : {v[6:0], v[7]};
            if (nv != v) exp_leds.push_back(nv);
            v = nv;
        end
        model_last = v;
        exp_done.push_back(v);
    endtask

    task automatic send(input logic [7:0] p, input logic d, input logic [7:0] s, output bit acc);
        cmd_valid   = 1'b1;
        cmd_pattern = p;
        cmd_dir     = d;
        cmd_steps   = s;
        acc         = cmd_ready;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (acc) model_cmd(p, d, s);
        $display("push pattern=%02h dir=%0d steps=%0d accepted=%0d", p, d, s, acc);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (busy === 1'b0 && fifo_count === 3'd0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_idle"}, 32'(ok), 32'd1);
        chk({tag, "_drain"}, 32'(exp_leds.size() + exp_done.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (leds !== prev_leds) begin
                if (exp_leds.size() == 0) chk("leds_unexpected", 32'(leds), 32'(prev_leds));
                else chk("leds_seq", 32'(leds), 32'(exp_leds.pop_front()));
                prev_leds = leds;
            end
            if (done !== 1'b0) begin
                if (exp_done.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
                else begin
                    chk("done_leds", 32'(leds), 32'(exp_done.pop_front()));
                    done_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         acc;
        int         n_acc;
        int         done_before;
        logic [7:0] p;

        // Reset state
        rst = 1'b1;
        tick(3);
        chk("rst_leds", 32'(leds), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        tick(1);
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);
        mon_en = 1'b1;

        // Rotate left 3 from 1F with exact latency
        send(8'h1F, 1'b0, 8'd3, acc);
        chk("t1_acc", 32'(acc), 32'd1);
        tick(1);
        chk("t1_load_busy", 32'(busy), 32'd1);
        chk("t1_load_leds", 32'(leds), 32'h00);
        tick(1);
        chk("t1_e2_leds", 32'(leds), 32'h1F);
        tick(3);
        chk("t1_e5_leds", 32'(leds), 32'h1F);
        tick(1);
        chk("t1_e6_leds", 32'(leds), 32'h3E);
        wait_idle("t1");
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        // Rotate right 2 from 81, then a zero-step command
        send(8'h81, 1'b1, 8'd2, acc);
        wait_idle("t2a");
        chk("t2_leds", 32'(leds), 32'h60);
        send(8'hAA, 1'b0, 8'd0, acc);
        tick(2);
        chk("t2_zero_leds", 32'(leds), 32'hAA);
        chk("t2_zero_done", 32'(done), 32'd1);
        wait_idle("t2b");
        chk("t2_done_cnt", 32'(done_cnt), 32'd3);

        // Hold cmd_valid 6 cycles: 5 accepted, ready low when full
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                chk("full_ready", 32'(cmd_ready), 32'd0);
                chk("full_count", 32'(fifo_count), 32'd4);
            end
            p = 8'h01 << i;
            send(p, 1'b1, 8'd1, acc);
            chk("fifo_acc", 32'(acc), (i < 5) ? 32'd1 : 32'd0);
            if (acc) n_acc++;
        end
        chk("fifo_n_acc", 32'(n_acc), 32'd5);
        wait_idle("t3");
        chk("t3_done_cnt", 32'(done_cnt), 32'd8);

        // Pause 10 cycles mid-RUN delays the first rotation by 10
        send(8'h01, 1'b0, 8'd2, acc);
        tick(2);
        chk("t4_e2_leds", 32'(leds), 32'h01);
        tick(1);
        pause = 1'b1;
        tick(10);
        pause = 1'b0;
        tick(2);
        chk("t4_e15_leds", 32'(leds), 32'h01);
        tick(1);
        chk("t4_e16_leds", 32'(leds), 32'h02);
        wait_idle("t4");
        chk("t4_final", 32'(leds), 32'h04);

        // Reset during RUN with two commands queued
        send(8'h0F, 1'b0, 8'd3, acc);
        send(8'hF0, 1'b1, 8'd2, acc);
        send(8'h3C, 1'b0, 8'd1, acc);
        tick(3);
        chk("t5_count", 32'(fifo_count), 32'd2);
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_leds", 32'(leds), 32'h0F);
        done_before = done_cnt;
        mon_en = 1'b0;
        rst = 1'b1;
        tick(1);
        chk("t5_rst_leds", 32'(leds), 32'h00);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_count", 32'(fifo_count), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        exp_leds.delete();
        exp_done.delete();
        model_last = 8'h00;
        prev_leds  = 8'h00;
        rst = 1'b0;
        mon_en = 1'b1;
        tick(20);
        chk("t5_quiet_leds", 32'(leds), 32'h00);
        chk("t5_quiet_busy", 32'(busy), 32'd0);
        chk("t5_quiet_done", 32'(done_cnt), 32'(done_before));

        // Push and pop on the same edge at fifo_count=1
        send(8'hC3, 1'b1, 8'd1, acc);
        chk("t6_count_a", 32'(fifo_count), 32'd1);
        send(8'h5A, 1'b0, 8'd1, acc);
        chk("t6_count_b", 32'(fifo_count), 32'd1);
        wait_idle("t6");
        chk("t6_final", 32'(leds), 32'hB4);
        chk("total_done", 32'(done_cnt), 32'd11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
